ifu_fetch: RTL

//  Instruction fetch unit: owns the PC, issues single-outstanding fetches on the

---
 rtl/ifu_fetch_if.sv | 37 +++
 rtl/ifu_fetch.sv | 102 ++++++++++
 2 files changed

// File: rtl/ifu_fetch_if.sv
// Instruction bus and IF/ID slot signals of the fetch unit.
// master: fetch unit side; slave: memory / decode side.
interface ifu_fetch_if;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_ready_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_gnt_i,
        input  ibus_rvalid_i,
        input  ibus_rdata_i,
        output if_valid_o,
        output if_pc_o,
        output if_inst_o,
        input  if_ready_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_gnt_i,
        output ibus_rvalid_i,
        output ibus_rdata_i,
        input  if_valid_o,
        input  if_pc_o,
        input  if_inst_o,
        output if_ready_i
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC owner, single-outstanding ibus fetch,
// redirect kill/flush and a one-entry valid/ready output slot.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_flag_in,
    input  logic [31:0] jump_addr_in,
    input  logic        hold_flag_in,
    ifu_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] pc_inflight, pc_inflight_nx;
    logic        slot_valid, slot_valid_nx;
    logic [31:0] slot_pc, slot_pc_nx;
    logic [31:0] slot_inst, slot_inst_nx;
    logic        slot_free;
    logic        req;
    logic        consumed;

    assign slot_free = !slot_valid || bus.if_ready_i;
    assign consumed  = slot_valid && bus.if_ready_i;

    assign req = rst_n && (state == IDLE) && !hold_flag_in
               && !jump_flag_in && slot_free;

    assign bus.ibus_req_o  = req;
    assign bus.ibus_addr_o = pc;
    assign bus.if_valid_o  = slot_valid;
    assign bus.if_pc_o     = slot_pc;
    assign bus.if_inst_o   = slot_inst;

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        pc_inflight_nx = pc_inflight;
        slot_valid_nx  = consumed ? 1'b0 : slot_valid;
        slot_pc_nx     = slot_pc;
        slot_inst_nx   = slot_inst;

        if (jump_flag_in) begin
            pc_nx         = jump_addr_in & ~32'h3;
            slot_valid_nx = 1'b0;
            // A fetch still in flight must have its response swallowed
            unique case (state)
                WAIT:    state_nx = bus.ibus_rvalid_i ? IDLE : DROP;
                DROP:    state_nx = bus.ibus_rvalid_i ? IDLE : DROP;
                default: state_nx = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    if (req && bus.ibus_gnt_i) begin
                        pc_inflight_nx = pc;
                        pc_nx          = pc + 32'd4;
                        state_nx       = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.ibus_rvalid_i) begin
                        slot_valid_nx = 1'b1;
                        slot_pc_nx    = pc_inflight;
                        slot_inst_nx  = bus.ibus_rdata_i;
                        state_nx      = IDLE;
                    end
                end
                DROP: begin
                    if (bus.ibus_rvalid_i) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pc_inflight <= 32'h0;
            slot_valid  <= 1'b0;
            slot_pc     <= 32'h0;
            slot_inst   <= 32'h0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            pc_inflight <= pc_inflight_nx;
            slot_valid  <= slot_valid_nx;
            slot_pc     <= slot_pc_nx;
            slot_inst   <= slot_inst_nx;
        end
    end

endmodule
